// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared encodings for the multicycle MIPS-subset control path.
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

  localparam int c_STATE_W = 4;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_MA   = 4'd2,
    ST_MR   = 4'd3,
    ST_WBL  = 4'd4,
    ST_MW   = 4'd5,
    ST_EXR  = 4'd6,
    ST_WBR  = 4'd7,
    ST_EXI  = 4'd8,
    ST_WBI  = 4'd9,
    ST_BR   = 4'd10,
    ST_JMP  = 4'd11,
    ST_TRAP = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_BNE   = 3'd4,
    CLS_J     = 3'd5,
    CLS_IALU  = 3'd6,
    CLS_ILL   = 3'd7
  } instr_cls_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_NOR = 6'b100111;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_NOR = 3'b101;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  localparam logic [1:0] c_SRCB_B       = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
  localparam logic [1:0] c_SRCB_IMM     = 2'b10;
  localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_ctr_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctr_decode
// Brief    : Maps opcode/funct to instruction class, ALU operation and
//            overflow-checking flag; flags unsupported encodings.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctr_decode
  import mc_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_ctr,
  output instr_cls_t  o_cls,
  output logic        o_ovf_chk,
  output logic        o_illegal
);

  always_comb begin
    o_alu_ctr = c_ALU_ADD;
    o_cls     = CLS_ILL;
    o_ovf_chk = 1'b0;
    case (i_opcode)
      c_OP_RTYPE: begin
        o_cls = CLS_RTYPE;
        case (i_funct)
          c_FN_ADD: begin o_alu_ctr = c_ALU_ADD; o_ovf_chk = 1'b1; end
          c_FN_SUB: begin o_alu_ctr = c_ALU_SUB; o_ovf_chk = 1'b1; end
          c_FN_AND: o_alu_ctr = c_ALU_AND;
          c_FN_OR:  o_alu_ctr = c_ALU_OR;
          c_FN_NOR: o_alu_ctr = c_ALU_NOR;
          c_FN_SLT: o_alu_ctr = c_ALU_SLT;
          default:  o_cls     = CLS_ILL;
        endcase
      end
      c_OP_LW:   o_cls = CLS_LW;
      c_OP_SW:   o_cls = CLS_SW;
      // Branches compare by subtraction so the ALU zero flag decides.
      c_OP_BEQ:  begin o_cls = CLS_BEQ;  o_alu_ctr = c_ALU_SUB; end
      c_OP_BNE:  begin o_cls = CLS_BNE;  o_alu_ctr = c_ALU_SUB; end
      c_OP_J:    o_cls = CLS_J;
      c_OP_ADDI: begin o_cls = CLS_IALU; o_alu_ctr = c_ALU_ADD; o_ovf_chk = 1'b1; end
      c_OP_ANDI: begin o_cls = CLS_IALU; o_alu_ctr = c_ALU_AND; end
      c_OP_ORI:  begin o_cls = CLS_IALU; o_alu_ctr = c_ALU_OR;  end
      c_OP_SLTI: begin o_cls = CLS_IALU; o_alu_ctr = c_ALU_SLT; end
      default:   o_cls = CLS_ILL;
    endcase
  end

  assign o_illegal = (o_cls == CLS_ILL);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) driving
//            datapath enables, mux selects and ALU_Ctr; memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W      = c_STATE_W,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALU_Ctr,
  output logic               exc_ovf,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;
  logic       r_ovf;

  logic       w_in_id;
  logic [5:0] w_dec_op;
  logic [5:0] w_dec_fn;
  logic [2:0] w_alu;
  instr_cls_t w_cls;
  logic       w_ovf_chk;
  logic       w_ill;

  // In ID the decoder sees the live IR fields so dispatch happens without an
  // extra cycle; afterwards it sees only the latched copy.
  assign w_in_id  = (r_state == ST_ID);
  assign w_dec_op = w_in_id ? opcode : r_op;
  assign w_dec_fn = w_in_id ? funct  : r_funct;

  alu_ctr_decode u_dec (
    .i_opcode  (w_dec_op),
    .i_funct   (w_dec_fn),
    .o_alu_ctr (w_alu),
    .o_cls     (w_cls),
    .o_ovf_chk (w_ovf_chk),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IF;
      r_op    <= '0;
      r_funct <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_in_id) begin
        r_op    <= opcode;
        r_funct <= funct;
      end
      if (r_state == ST_EXR || r_state == ST_EXI) begin
        r_ovf <= overflow & w_ovf_chk;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = c_PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = c_SRCB_B;
    ALU_Ctr     = c_ALU_AND;
    exc_ovf     = 1'b0;
    illegal     = 1'b0;
    // Reset forces every output low, so an aborted instruction writes nothing.
    if (!rst) begin
      case (r_state)
        ST_IF: begin
          MemRead  = 1'b1;
          ALUSrcB  = c_SRCB_FOUR;
          ALU_Ctr  = c_ALU_ADD;
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
          if (mem_ready) w_next = ST_ID;
        end
        ST_ID: begin
          ALUSrcB = c_SRCB_IMM_SH2;
          ALU_Ctr = c_ALU_ADD;
          if (w_ill) begin
            w_next = ILLEGAL_TRAP ? ST_TRAP : ST_IF;
          end else begin
            case (w_cls)
              CLS_LW, CLS_SW:   w_next = ST_MA;
              CLS_RTYPE:        w_next = ST_EXR;
              CLS_BEQ, CLS_BNE: w_next = ST_BR;
              CLS_J:            w_next = ST_JMP;
              CLS_IALU:         w_next = ST_EXI;
              default:          w_next = ST_IF;
            endcase
          end
        end
        ST_MA: begin
          ALUSrcA = 1'b1;
          ALUSrcB = c_SRCB_IMM;
          ALU_Ctr = c_ALU_ADD;
          w_next  = (w_cls == CLS_SW) ? ST_MW : ST_MR;
        end
        ST_MR: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) w_next = ST_WBL;
        end
        ST_WBL: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          w_next   = ST_IF;
        end
        ST_MW: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) w_next = ST_IF;
        end
        ST_EXR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = c_SRCB_B;
          ALU_Ctr = w_alu;
          w_next  = ST_WBR;
        end
        ST_WBR: begin
          RegDst   = 1'b1;
          RegWrite = ~r_ovf;
          exc_ovf  = r_ovf;
          w_next   = ST_IF;
        end
        ST_EXI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = c_SRCB_IMM;
          ALU_Ctr = w_alu;
          w_next  = ST_WBI;
        end
        ST_WBI: begin
          RegWrite = ~r_ovf;
          exc_ovf  = r_ovf;
          w_next   = ST_IF;
        end
        ST_BR: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = c_SRCB_B;
          ALU_Ctr     = c_ALU_SUB;
          PCSource    = c_PCSRC_ALUOUT;
          PCWriteCond = (w_cls == CLS_BNE) ? ~zero : zero;
          w_next      = ST_IF;
        end
        ST_JMP: begin
          PCWrite  = 1'b1;
          PCSource = c_PCSRC_JUMP;
          w_next   = ST_IF;
        end
        ST_TRAP: begin
          illegal = 1'b1;
          w_next  = ST_TRAP;
        end
        default: w_next = ST_IF;
      endcase
    end
  end

  assign state = rst ? '0 : STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Randomized self-checking bench for multicycle_ctrl against an
//            instruction-level reference of state sequences and outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int S_IF = 0, S_ID = 1, S_MA = 2, S_MR = 3, S_WBL = 4, S_MW = 5;
  localparam int S_EXR = 6, S_WBR = 7, S_EXI = 8, S_WBI = 9, S_BR = 10;
  localparam int S_JMP = 11, S_TRAP = 12;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_J = 5, K_I = 6;

  // add sub and or nor slt lw sw beq bne j addi andi ori slti
  localparam logic [5:0] T_OP [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
  localparam logic [5:0] T_FN [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a,
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  localparam int T_KIND [15] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 6};
  localparam logic [2:0] T_ALU [15] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b101,
    3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b111};
  localparam bit T_OVF [15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, exc_ovf, illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALU_Ctr;
  logic [3:0] state;
  logic [18:0] w_obs;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Ctr(ALU_Ctr),
    .exc_ovf(exc_ovf), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign w_obs = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_Ctr, exc_ovf, illegal};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output bundle for one cycle, straight from the per-state table.
  function automatic logic [18:0] exp_out(input int st, input int idx, input bit mr,
                                          input bit zr, input bit sup);
    logic       pcw = 0, pcc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic       m2r = 0, rdst = 0, rw = 0, asa = 0, eo = 0, ill = 0;
    logic [1:0] pcs = 0, asb = 0;
    logic [2:0] alu = 0;
    case (st)
      S_IF:   begin mrd = 1; asb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
      S_ID:   begin asb = 2'b11; alu = 3'b010; end
      S_MA:   begin asa = 1; asb = 2'b10; alu = 3'b010; end
      S_MR:   begin mrd = 1; iord = 1; end
      S_WBL:  begin rw = 1; m2r = 1; end
      S_MW:   begin mwr = 1; iord = 1; end
      S_EXR:  begin asa = 1; alu = T_ALU[idx]; end
      S_WBR:  begin rdst = 1; rw = !sup; eo = sup; end
      S_EXI:  begin asa = 1; asb = 2'b10; alu = T_ALU[idx]; end
      S_WBI:  begin rw = !sup; eo = sup; end
      S_BR:   begin asa = 1; alu = 3'b110; pcs = 2'b01;
                    pcc = (T_KIND[idx] == K_BEQ) ? zr : !zr; end
      S_JMP:  begin pcw = 1; pcs = 2'b10; end
      S_TRAP: ill = 1;
      default: ;
    endcase
    return {pcw, pcc, pcs, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, alu, eo, ill};
  endfunction

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    funct = 6'($urandom);
    #2;
    chk_eq({tag, " rst state"}, 32'(state), 32'd0);
    chk_eq({tag, " rst outs"}, 32'(w_obs), 32'd0);
    @(posedge clk); #1;
  endtask

  // Runs one instruction; abort_at >= 0 asserts rst in that cycle instead.
  task automatic run_instr(input int idx, input int if_st, input int mem_st,
                           input bit ovf, input bit zr, input int abort_at);
    int seq[$];
    int st;
    bit rdy;
    bit sup;
    sup = ovf && T_OVF[idx];
    repeat (if_st + 1) seq.push_back(S_IF);
    seq.push_back(S_ID);
    case (T_KIND[idx])
      K_R:         begin seq.push_back(S_EXR); seq.push_back(S_WBR); end
      K_LW:        begin seq.push_back(S_MA); repeat (mem_st + 1) seq.push_back(S_MR);
                         seq.push_back(S_WBL); end
      K_SW:        begin seq.push_back(S_MA); repeat (mem_st + 1) seq.push_back(S_MW); end
      K_BEQ, K_BNE: seq.push_back(S_BR);
      K_J:         seq.push_back(S_JMP);
      default:     begin seq.push_back(S_EXI); seq.push_back(S_WBI); end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        reset_cycle($sformatf("abort i%0d c%0d", idx, i));
        rst = 1'b0;
        return;
      end
      st = seq[i];
      if (st == S_IF || st == S_MR || st == S_MW)
        rdy = (i == seq.size() - 1) || (seq[i+1] != st);
      else
        rdy = 1'($urandom);
      mem_ready = rdy;
      opcode    = (st == S_ID) ? T_OP[idx] : 6'($urandom);
      funct     = (st == S_ID && T_KIND[idx] == K_R) ? T_FN[idx] : 6'($urandom);
      overflow  = (st == S_EXR || st == S_EXI) ? ovf : 1'($urandom);
      zero      = (st == S_BR) ? zr : 1'($urandom);
      #2;
      chk_eq($sformatf("state i%0d c%0d", idx, i), 32'(state), 32'(st));
      chk_eq($sformatf("outs i%0d c%0d st%0d", idx, i, st), 32'(w_obs),
             32'(exp_out(st, idx, rdy, zr, sup)));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_trap(input logic [5:0] op, input logic [5:0] fn);
    mem_ready = 1'b1;
    #2;
    chk_eq("trap IF state", 32'(state), S_IF);
    @(posedge clk); #1;
    opcode = op;
    funct = fn;
    mem_ready = 1'($urandom);
    #2;
    chk_eq("trap ID state", 32'(state), S_ID);
    chk_eq("trap ID outs", 32'(w_obs), 32'(exp_out(S_ID, 0, 1'b0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      zero = 1'($urandom);
      overflow = 1'($urandom);
      #2;
      chk_eq($sformatf("trap hold c%0d state", c), 32'(state), S_TRAP);
      chk_eq($sformatf("trap hold c%0d outs", c), 32'(w_obs),
             32'(exp_out(S_TRAP, 0, 1'b0, 1'b0, 1'b0)));
      @(posedge clk); #1;
    end
    reset_cycle("trap exit");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      #2;
      chk_eq("reset state", 32'(state), 32'd0);
      chk_eq("reset outs", 32'(w_obs), 32'd0);
    end
    rst = 1'b0;
    // Directed cases first: add, sub with overflow, stalled lw, branches, slti.
    run_instr(0, 0, 0, 1'b0, 1'b0, -1);
    run_instr(1, 0, 0, 1'b1, 1'b0, -1);
    run_instr(6, 0, 2, 1'b0, 1'b0, -1);
    run_instr(8, 1, 0, 1'b0, 1'b1, -1);
    run_instr(9, 0, 0, 1'b0, 1'b1, -1);
    run_instr(14, 0, 0, 1'b0, 1'b0, -1);
    run_instr(11, 0, 0, 1'b1, 1'b0, -1);
    run_instr(7, 2, 1, 1'b0, 1'b0, -1);
    run_instr(10, 0, 0, 1'b0, 1'b0, -1);
    run_instr(0, 0, 0, 1'b1, 1'b0, 2);
    run_trap(6'b111111, 6'h00);
    run_trap(6'b000000, 6'b111111);
    for (int n = 0; n < 200; n++) begin
      int idx;
      int ab;
      idx = int'($urandom_range(0, 14));
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(idx, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ab);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
